// File: rtl/rcpu_io_uart_if.sv
// rcpu_io_uart_if
// IO bus between the RCPU core and its UART peripheral. The core issues
// single-cycle read/write strobes with a word-aligned address; the peripheral
// answers reads with registered data one cycle later.
//   io_read_enable   core -> periph  read strobe
//   io_write_enable  core -> periph  write strobe
//   io_address       core -> periph  16-bit register address (multiple of 4)
//   io_write_data    core -> periph  16-bit write data
//   io_read_data     periph -> core  16-bit registered read data
interface rcpu_io_uart_if;
    logic        io_read_enable;
    logic        io_write_enable;
    logic [15:0] io_address;
    logic [15:0] io_write_data;
    logic [15:0] io_read_data;

    modport master (
        output io_read_enable,
        output io_write_enable,
        output io_address,
        output io_write_data,
        input  io_read_data
    );

    modport slave (
        input  io_read_enable,
        input  io_write_enable,
        input  io_address,
        input  io_write_data,
        output io_read_data
    );
endinterface

// File: rtl/rcpu_io_uart.sv
// rcpu_io_uart
// IO-bus UART peripheral for the RCPU core: an 8N1 transmitter fed by a byte
// FIFO, an 8N1 receiver with a one-byte holding register, and a status
// register for polling.
//   clk      system clock
//   reset    synchronous, active-high reset
//   bus      IO bus (slave side): strobes, address, write data, read data
//   uart_tx  serial output, idle high
//   uart_rx  asynchronous serial input
// Register map: 0x0000 TXDATA, 0x0004 RXDATA, 0x0008 STATUS.
module rcpu_io_uart #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TX_DEPTH     = 8
) (
    input  logic          clk,
    input  logic          reset,
    rcpu_io_uart_if.slave bus,
    output logic          uart_tx,
    input  logic          uart_rx
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(TX_DEPTH);

    localparam logic [15:0] ADDR_TXDATA = 16'h0000;
    localparam logic [15:0] ADDR_RXDATA = 16'h0004;
    localparam logic [15:0] ADDR_STATUS = 16'h0008;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Bus decode
    logic rdRxData, rdStatus, wrTxData;
    assign rdRxData = bus.io_read_enable  && (bus.io_address == ADDR_RXDATA);
    assign rdStatus = bus.io_read_enable  && (bus.io_address == ADDR_STATUS);
    assign wrTxData = bus.io_write_enable && (bus.io_address == ADDR_TXDATA);

    // Only the low byte of write data reaches the FIFO.
    logic unusedWdata;
    assign unusedWdata = ^bus.io_write_data[15:8];

    // TX FIFO state
    logic [7:0]  fifoMem_q [TX_DEPTH];
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [AW:0] fifoCount_q;
    logic        txFull, txEmpty, txPush, txPop, txDrop;

    // TX shifter state
    logic [1:0]    txState_q;
    logic [CW-1:0] txCnt_q;
    logic [2:0]    txBitIdx_q;
    logic [7:0]    txShift_q;
    logic          txOut_q;

    assign txFull  = (fifoCount_q == DEPTH);
    assign txEmpty = (fifoCount_q == '0);

    // The shifter pops when idle or at the very end of a stop bit, which is
    // what lets back-to-back frames run without an idle cycle between them.
    assign txPop  = !txEmpty && ((txState_q == ST_IDLE) ||
                                 ((txState_q == ST_STOP) && (txCnt_q == '0)));
    // A pop in the same cycle frees an entry, so a push into a full FIFO
    // still lands in that case.
    assign txPush = wrTxData && (!txFull || txPop);
    assign txDrop = wrTxData && txFull && !txPop;

    // FIFO pointers and occupancy; pointers wrap naturally at TX_DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (txPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (txPop)  rdPtr_q <= rdPtr_q + 1'b1;
            fifoCount_q <= fifoCount_q + (AW + 1)'(txPush) - (AW + 1)'(txPop);
        end
    end

    // FIFO storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (txPush) fifoMem_q[wrPtr_q] <= bus.io_write_data[7:0];
    end

    // TX frame sequencer. uart_tx comes straight from txOut_q so the line
    // never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            txState_q  <= ST_IDLE;
            txCnt_q    <= '0;
            txBitIdx_q <= '0;
            txShift_q  <= '0;
            txOut_q    <= 1'b1;
        end else begin
            case (txState_q)
                ST_IDLE: begin
                    if (txPop) begin
                        txShift_q <= fifoMem_q[rdPtr_q];
                        txCnt_q   <= CNT_MAX;
                        txOut_q   <= 1'b0;
                        txState_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (txCnt_q == '0) begin
                        txCnt_q    <= CNT_MAX;
                        txBitIdx_q <= '0;
                        txOut_q    <= txShift_q[0];
                        txState_q  <= ST_DATA;
                    end else begin
                        txCnt_q <= txCnt_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (txCnt_q == '0) begin
                        txCnt_q <= CNT_MAX;
                        if (txBitIdx_q == 3'd7) begin
                            txOut_q   <= 1'b1;
                            txState_q <= ST_STOP;
                        end else begin
                            txBitIdx_q <= txBitIdx_q + 1'b1;
                            txShift_q  <= txShift_q >> 1;
                            txOut_q    <= txShift_q[1];
                        end
                    end else begin
                        txCnt_q <= txCnt_q - 1'b1;
                    end
                end
                default: begin
                    if (txCnt_q == '0) begin
                        if (txPop) begin
                            txShift_q <= fifoMem_q[rdPtr_q];
                            txCnt_q   <= CNT_MAX;
                            txOut_q   <= 1'b0;
                            txState_q <= ST_START;
                        end else begin
                            txState_q <= ST_IDLE;
                        end
                    end else begin
                        txCnt_q <= txCnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign uart_tx = txOut_q;

    // RX synchronizer plus one extra flop for falling-edge detection.
    // All reset high so an idle line never looks like a start bit.
    logic rxSync1_q, rxSync2_q, rxLast_q, rxFall;
    always_ff @(posedge clk) begin
        if (reset) begin
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
            rxLast_q  <= 1'b1;
        end else begin
            rxSync1_q <= uart_rx;
            rxSync2_q <= rxSync1_q;
            rxLast_q  <= rxSync2_q;
        end
    end
    assign rxFall = rxLast_q && !rxSync2_q;

    logic [1:0]    rxState_q;
    logic [CW-1:0] rxCnt_q;
    logic [2:0]    rxBitIdx_q;
    logic [7:0]    rxShift_q;
    logic          rxDone;

    // Completed frame with a valid stop bit; framing errors never raise it.
    assign rxDone = (rxState_q == ST_STOP) && (rxCnt_q == '0) && rxSync2_q;

    // RX frame sequencer: half a bit after the falling edge checks the start
    // bit, then every full bit period samples the next bit near its centre.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxState_q  <= ST_IDLE;
            rxCnt_q    <= '0;
            rxBitIdx_q <= '0;
            rxShift_q  <= '0;
        end else begin
            case (rxState_q)
                ST_IDLE: begin
                    if (rxFall) begin
                        rxCnt_q   <= CNT_HALF;
                        rxState_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (rxCnt_q == '0) begin
                        if (rxSync2_q) begin
                            rxState_q <= ST_IDLE;
                        end else begin
                            rxCnt_q    <= CNT_MAX;
                            rxBitIdx_q <= '0;
                            rxState_q  <= ST_DATA;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rxCnt_q == '0) begin
                        rxShift_q <= {rxSync2_q, rxShift_q[7:1]};
                        rxCnt_q   <= CNT_MAX;
                        if (rxBitIdx_q == 3'd7) begin
                            rxState_q <= ST_STOP;
                        end else begin
                            rxBitIdx_q <= rxBitIdx_q + 1'b1;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q - 1'b1;
                    end
                end
                default: begin
                    if (rxCnt_q == '0) begin
                        rxState_q <= ST_IDLE;
                    end else begin
                        rxCnt_q <= rxCnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Read mux; STATUS shows flag values from before any clear this cycle.
    logic [7:0]  rxByte_q;
    logic        rxValid_q, rxOverrun_q, txOverflow_q;
    logic [15:0] readData_q;
    logic [15:0] readMux;

    always_comb begin
        readMux = '0;
        case (bus.io_address)
            ADDR_RXDATA: readMux = {8'h00, rxByte_q};
            ADDR_STATUS: readMux = {11'b0, txOverflow_q, rxOverrun_q,
                                    rxValid_q, txEmpty, txFull};
            default:     readMux = '0;
        endcase
    end

    // Read data register and sticky flags. A new event in the same cycle as
    // a STATUS read wins over the clear so it is not lost. A frame that
    // completes while RXDATA is being read is not an overrun: the old byte
    // is consumed by that read.
    always_ff @(posedge clk) begin
        if (reset) begin
            readData_q   <= '0;
            rxByte_q     <= '0;
            rxValid_q    <= 1'b0;
            rxOverrun_q  <= 1'b0;
            txOverflow_q <= 1'b0;
        end else begin
            if (bus.io_read_enable) readData_q <= readMux;

            if (rxDone) begin
                rxByte_q  <= rxShift_q;
                rxValid_q <= 1'b1;
            end else if (rdRxData) begin
                rxValid_q <= 1'b0;
            end

            if (rdStatus) begin
                rxOverrun_q  <= 1'b0;
                txOverflow_q <= 1'b0;
            end
            if (rxDone && rxValid_q && !rdRxData) rxOverrun_q <= 1'b1;
            if (txDrop) txOverflow_q <= 1'b1;
        end
    end

    assign bus.io_read_data = readData_q;

endmodule

// File: tb/tb_rcpu_io_uart.sv
// tb_rcpu_io_uart
// Directed self-checking bench for rcpu_io_uart with CLKS_PER_BIT=4 and
// TX_DEPTH=8. Each scenario task drives the bus/serial line and compares
// against hand-computed values. A background decoder turns uart_tx back into
// bytes and records the idle gap before each frame.
module tb_rcpu_io_uart;

    localparam int CPB = 4;

    localparam logic [15:0] A_TXDATA = 16'h0000;
    localparam logic [15:0] A_RXDATA = 16'h0004;
    localparam logic [15:0] A_STATUS = 16'h0008;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic uart_tx;
    logic uart_rx = 1'b1;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] txBytes[$];
    int         txGaps[$];

    rcpu_io_uart_if ioBus ();

    rcpu_io_uart #(
        .CLKS_PER_BIT(CPB),
        .TX_DEPTH    (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (ioBus),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    // Bus idles with no strobes.
    initial begin
        ioBus.io_read_enable  = 1'b0;
        ioBus.io_write_enable = 1'b0;
        ioBus.io_address      = '0;
        ioBus.io_write_data   = '0;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Serial decoder for uart_tx: samples each bit at its centre and records
    // how many idle cycles preceded the frame (0 means back-to-back).
    initial begin : txDecoder
        int         idle;
        logic [7:0] b;
        @(negedge reset);
        forever begin
            idle = 0;
            while (uart_tx !== 1'b0) begin
                @(posedge clk); #1;
                idle++;
            end
            repeat (CPB / 2) @(posedge clk);
            #1;
            b = '0;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1;
                b[i] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            repeat (CPB / 2) @(posedge clk);
            #1;
            txBytes.push_back(b);
            txGaps.push_back(idle);
        end
    end

    // Bus helpers: called at posedge+1, return at posedge+1 after the strobe.
    task automatic busWrite(input logic [15:0] addr, input logic [15:0] data);
        ioBus.io_write_enable = 1'b1;
        ioBus.io_address      = addr;
        ioBus.io_write_data   = data;
        @(posedge clk); #1;
        ioBus.io_write_enable = 1'b0;
    endtask

    task automatic busRead(input logic [15:0] addr, output logic [15:0] data);
        ioBus.io_read_enable = 1'b1;
        ioBus.io_address     = addr;
        @(posedge clk); #1;
        ioBus.io_read_enable = 1'b0;
        data = ioBus.io_read_data;
    endtask

    task automatic sendRx(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        testsRun++;
        if (uart_tx !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_uart_tx: got %b expected 1", uart_tx);
        end
        testsRun++;
        if (ioBus.io_read_data !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_read_data: got %h expected 0000", ioBus.io_read_data);
        end
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL reset_status: got %h expected 0002", d);
        end
    endtask

    task automatic test_tx_frame();
        logic [15:0] d;
        logic [9:0]  frame;
        int          wait_cycles;
        int          bad;
        frame = {1'b1, 8'h55, 1'b0};
        busWrite(A_TXDATA, 16'h1255);
        wait_cycles = 0;
        while (uart_tx !== 1'b0 && wait_cycles < 20) begin
            @(posedge clk); #1;
            wait_cycles++;
        end
        testsRun++;
        if (uart_tx !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tx_start_seen: got %b expected 0 within 20 cycles", uart_tx);
        end
        for (int l = 0; l < 10; l++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                if (uart_tx !== frame[l]) bad++;
                @(posedge clk); #1;
            end
            testsRun++;
            if (bad != 0) begin
                testsFailed++;
                $display("[TB] FAIL tx_level_%0d: got %0d wrong cycles expected level %b for all %0d",
                         l, bad, frame[l], CPB);
            end
        end
        testsRun++;
        if (uart_tx !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL tx_idle_after: got %b expected 1", uart_tx);
        end
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL tx_status_after: got %h expected 0002", d);
        end
    endtask

    task automatic test_addr();
        logic [15:0] d;
        busWrite(A_STATUS, 16'hFFFF);
        busWrite(16'h000C, 16'hFFFF);
        busWrite(A_RXDATA, 16'h00AB);
        busRead(16'h000C, d);
        testsRun++;
        if (d !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL addr_unmapped_read: got %h expected 0000", d);
        end
        busRead(A_TXDATA, d);
        testsRun++;
        if (d !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL addr_txdata_read: got %h expected 0000", d);
        end
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL addr_status_unchanged: got %h expected 0002", d);
        end
        testsRun++;
        if (uart_tx !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL addr_no_tx: got %b expected 1", uart_tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [7:0]  expBytes [9];
        int          guard;
        expBytes[0] = 8'h3C;
        for (int i = 1; i < 9; i++) expBytes[i] = 8'(i);
        txBytes.delete();
        txGaps.delete();
        busWrite(A_TXDATA, 16'h003C);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i <= 9; i++) busWrite(A_TXDATA, 16'(i));
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h0011) begin
            testsFailed++;
            $display("[TB] FAIL b2b_status_overflow: got %h expected 0011", d);
        end
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h0001) begin
            testsFailed++;
            $display("[TB] FAIL b2b_status_cleared: got %h expected 0001", d);
        end
        guard = 0;
        while (txBytes.size() < 9 && guard < 600) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (60) @(posedge clk);
        #1;
        testsRun++;
        if (txBytes.size() != 9) begin
            testsFailed++;
            $display("[TB] FAIL b2b_frame_count: got %0d expected 9", txBytes.size());
        end
        for (int i = 0; i < 9 && i < txBytes.size(); i++) begin
            testsRun++;
            if (txBytes[i] !== expBytes[i]) begin
                testsFailed++;
                $display("[TB] FAIL b2b_byte_%0d: got %h expected %h", i, txBytes[i], expBytes[i]);
            end
        end
        for (int i = 1; i < 9 && i < txGaps.size(); i++) begin
            testsRun++;
            if (txGaps[i] != 0) begin
                testsFailed++;
                $display("[TB] FAIL b2b_gap_%0d: got %0d idle cycles expected 0", i, txGaps[i]);
            end
        end
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL b2b_status_drained: got %h expected 0002", d);
        end
    endtask

    task automatic test_rx_single();
        logic [15:0] d;
        sendRx(8'hA5);
        repeat (4) @(posedge clk);
        #1;
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h0006) begin
            testsFailed++;
            $display("[TB] FAIL rx_status_valid: got %h expected 0006", d);
        end
        busRead(A_RXDATA, d);
        testsRun++;
        if (d !== 16'h00A5) begin
            testsFailed++;
            $display("[TB] FAIL rx_data: got %h expected 00a5", d);
        end
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL rx_status_consumed: got %h expected 0002", d);
        end
    endtask

    task automatic test_rx_overrun();
        logic [15:0] d;
        sendRx(8'h11);
        sendRx(8'h22);
        repeat (4) @(posedge clk);
        #1;
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h000E) begin
            testsFailed++;
            $display("[TB] FAIL ovr_status: got %h expected 000e", d);
        end
        busRead(A_RXDATA, d);
        testsRun++;
        if (d !== 16'h0022) begin
            testsFailed++;
            $display("[TB] FAIL ovr_data: got %h expected 0022", d);
        end
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL ovr_status_cleared: got %h expected 0002", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        int          lows;
        busWrite(A_TXDATA, 16'h0000);
        busWrite(A_TXDATA, 16'h0000);
        uart_rx = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        testsRun++;
        if (uart_tx !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_tx_active: got %b expected 0", uart_tx);
        end
        reset   = 1'b1;
        uart_rx = 1'b1;
        @(posedge clk); #1;
        testsRun++;
        if (uart_tx !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_tx_high: got %b expected 1", uart_tx);
        end
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            if (uart_tx !== 1'b1) lows++;
            @(posedge clk); #1;
        end
        testsRun++;
        if (lows != 0) begin
            testsFailed++;
            $display("[TB] FAIL mid_tx_stays_idle: got %0d low cycles expected 0", lows);
        end
        busRead(A_STATUS, d);
        testsRun++;
        if (d !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL mid_status: got %h expected 0002", d);
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_addr();
        test_back_to_back();
        test_rx_single();
        test_rx_overrun();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
